// File: rtl/multi_project_io_arbiter.sv
// -----------------------------------------------------------------------------
// multi_project_io_arbiter
//
// Purpose:
//   Shares the Caravel user-area pads and LA readback between NPROJ wrapped
//   projects. A project asks for the pads by raising its LA active bit,
//   active_i[ACT_BASE+k]. The active bits are first passed through a
//   synchroniser. The arbiter then grants the pads to at most one project.
//   Each switchover goes through a tristated guard interval of GUARD cycles.
//   During that interval every project is held in reset. The outgoing and
//   incoming projects therefore never drive the pads in the same cycle.
//   A multi-hot request is treated as a fault. While it persists the pads stay
//   tristated, and a sticky flag records that it happened.
//
//   The request interface is level based. There is no valid/ready handshake.
//   A project owns the pads for as long as its bit is the only active bit
//   within the ACT_BASE window.
//
// Ports:
//   wb_clk_i      system clock
//   wb_rst_n      asynchronous active-low reset
//   active_i      project enable bits (la_data_in[31:0])
//   proj_io_out   project k io_out at [k*IO_W +: IO_W]
//   proj_io_oeb   project k io_oeb, same packing
//   proj_la_out   project k la_data_out at [k*LA_W +: LA_W]
//   io_out        pad output (0 unless a project is running)
//   io_oeb        pad output-enable-bar (all 1 unless a project is running)
//   la_data_out   LA readback (0 unless a project is running)
//   proj_rst_n    per-project active-low reset; only the running project is released
//   state_o       FSM state: 0 OFF, 1 GUARD, 2 RUN, 3 FAULT
//   sel_o         selected / target project index
//   switch_cnt_o  saturating count of completed switchovers
//   fault_o       sticky flag: a multi-hot request was seen since reset
// -----------------------------------------------------------------------------
module multi_project_io_arbiter #(
  parameter int NPROJ       = 4,
  parameter int IO_W        = 38,
  parameter int LA_W        = 32,
  parameter int ACT_BASE    = 8,
  parameter int GUARD       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = (NPROJ > 1) ? $clog2(NPROJ) : 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic [31:0]           active_i,
  input  logic [NPROJ*IO_W-1:0] proj_io_out,
  input  logic [NPROJ*IO_W-1:0] proj_io_oeb,
  input  logic [NPROJ*LA_W-1:0] proj_la_out,
  output logic [IO_W-1:0]       io_out,
  output logic [IO_W-1:0]       io_oeb,
  output logic [LA_W-1:0]       la_data_out,
  output logic [NPROJ-1:0]      proj_rst_n,
  output logic [1:0]            state_o,
  output logic [SEL_W-1:0]      sel_o,
  output logic [7:0]            switch_cnt_o,
  output logic                  fault_o
);

  // Guard counter width. The counter only ever holds 0..GUARD-1.
  localparam int CNT_W = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Request synchroniser.
  // Only the NPROJ bits in the project window are sampled. The remaining
  // bits of active_i belong to other users of the LA bus.
  // ---------------------------------------------------------------------------
  logic [NPROJ-1:0] sync_q [SYNC_STAGES];
  logic [NPROJ-1:0] req;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= active_i[ACT_BASE +: NPROJ];
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign req = sync_q[SYNC_STAGES-1];

  // Bits outside the project window are deliberately ignored.
  logic unused_active;
  assign unused_active = ^active_i;

  // ---------------------------------------------------------------------------
  // Request classification: ZERO, ONE(req_idx) or MULTI.
  // req_multi goes high as soon as a set bit is found after an earlier set bit.
  // req_idx is meaningful only when the class is ONE.
  // ---------------------------------------------------------------------------
  logic             req_any;
  logic             req_multi;
  logic [SEL_W-1:0] req_idx;

  always_comb begin
    req_any   = 1'b0;
    req_multi = 1'b0;
    req_idx   = '0;
    for (int k = 0; k < NPROJ; k++) begin
      if (req[k]) begin
        req_multi = req_multi | req_any;
        req_any   = 1'b1;
        req_idx   = SEL_W'(k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [7:0]       swc_q,   swc_d;
  logic             fault_q, fault_d;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ST_OFF;
      sel_q   <= '0;
      cnt_q   <= '0;
      swc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      swc_q   <= swc_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    swc_d   = swc_q;
    fault_d = fault_q;

    unique case (state_q)
      ST_OFF: begin
        if (req_multi) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else if (req_any) begin
          state_d = ST_GUARD;
          sel_d   = req_idx;
          cnt_d   = '0;
        end
      end

      ST_GUARD: begin
        if (req_multi) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else if (!req_any) begin
          state_d = ST_OFF;
        end else if (req_idx != sel_q) begin
          // The target changed mid-guard. Restart the whole guard for the new project.
          sel_d = req_idx;
          cnt_d = '0;
        end else if (cnt_q == GUARD_LAST) begin
          // The guard is complete. Release the project and count the switchover.
          state_d = ST_RUN;
          if (swc_q != 8'hFF) begin
            swc_d = swc_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (req_multi) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else if (!req_any) begin
          state_d = ST_OFF;
        end else if (req_idx != sel_q) begin
          // Hand over directly to the new project. The guard state tristates the
          // pads and resets the outgoing project.
          state_d = ST_GUARD;
          sel_d   = req_idx;
          cnt_d   = '0;
        end
      end

      ST_FAULT: begin
        if (!req_any) begin
          state_d = ST_OFF;
        end else if (!req_multi) begin
          state_d = ST_GUARD;
          sel_d   = req_idx;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pad / LA routing.
  // This path is purely combinational from the registered state and from the
  // project inputs. Asserting reset therefore tristates the pads at once,
  // without waiting for a clock.
  // ---------------------------------------------------------------------------
  always_comb begin
    io_out      = '0;
    io_oeb      = '1;
    la_data_out = '0;
    proj_rst_n  = '0;
    if (state_q == ST_RUN) begin
      io_out      = proj_io_out[int'(sel_q)*IO_W +: IO_W];
      io_oeb      = proj_io_oeb[int'(sel_q)*IO_W +: IO_W];
      la_data_out = proj_la_out[int'(sel_q)*LA_W +: LA_W];
      for (int k = 0; k < NPROJ; k++) begin
        proj_rst_n[k] = (int'(sel_q) == k);
      end
    end
  end

  assign state_o      = state_q;
  assign sel_o        = sel_q;
  assign switch_cnt_o = swc_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_multi_project_io_arbiter.sv
module tb_multi_project_io_arbiter;

  localparam int NPROJ = 4;
  localparam int IO_W  = 38;
  localparam int LA_W  = 32;

  logic                  clk;
  logic                  wb_rst_n;
  logic [31:0]           active_i;
  logic [NPROJ*IO_W-1:0] proj_io_out;
  logic [NPROJ*IO_W-1:0] proj_io_oeb;
  logic [NPROJ*LA_W-1:0] proj_la_out;
  logic [IO_W-1:0]       io_out;
  logic [IO_W-1:0]       io_oeb;
  logic [LA_W-1:0]       la_data_out;
  logic [NPROJ-1:0]      proj_rst_n;
  logic [1:0]            state_o;
  logic [1:0]            sel_o;
  logic [7:0]            switch_cnt_o;
  logic                  fault_o;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [IO_W-1:0] OEB_OFF = '1;

  multi_project_io_arbiter dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (wb_rst_n),
    .active_i    (active_i),
    .proj_io_out (proj_io_out),
    .proj_io_oeb (proj_io_oeb),
    .proj_la_out (proj_la_out),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .la_data_out (la_data_out),
    .proj_rst_n  (proj_rst_n),
    .state_o     (state_o),
    .sel_o       (sel_o),
    .switch_cnt_o(switch_cnt_o),
    .fault_o     (fault_o)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Fixed per-project data patterns.
  // Every project has a distinct io_out, io_oeb and la pattern.
  // ---------------------------------------------------------------------------
  function automatic logic [IO_W-1:0] io_pat(input int k);
    return 38'h15_A5A5_0000 + 38'(k) * 38'h01_0101_0111;
  endfunction

  function automatic logic [IO_W-1:0] oeb_pat(input int k);
    return 38'h00_0F0F_0F00 | 38'(k);
  endfunction

  function automatic logic [LA_W-1:0] la_pat(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_projects();
    for (int k = 0; k < NPROJ; k++) begin
      proj_io_out[k*IO_W +: IO_W] = io_pat(k);
      proj_io_oeb[k*IO_W +: IO_W] = oeb_pat(k);
      proj_la_out[k*LA_W +: LA_W] = la_pat(k);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    wb_rst_n = 1'b0;
    active_i = '0;
    #2;
    tests_run++;
    if (io_oeb !== OEB_OFF || proj_rst_n !== 4'b0000 || io_out !== '0 || la_data_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_pads io_oeb=%h io_out=%h la=%h rst_n=%b required oeb all 1, others 0",
               io_oeb, io_out, la_data_out, proj_rst_n);
    end
    repeat (3) tick();
    wb_rst_n = 1'b1;
    repeat (20) tick();
    tests_run++;
    if (state_o !== 2'd0 || sel_o !== 2'd0 || switch_cnt_o !== 8'd0 || fault_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state state=%0d sel=%0d swc=%0d fault=%b required 0 0 0 0",
               state_o, sel_o, switch_cnt_o, fault_o);
    end
    tests_run++;
    if (io_oeb !== OEB_OFF || proj_rst_n !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_idle_pads io_oeb=%h rst_n=%b required all 1 / 0000", io_oeb, proj_rst_n);
    end
  endtask

  task automatic test_select();
    logic [1:0] exp_state;
    active_i = 32'h0000_0200;  // project 1
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_state = (e < 3) ? 2'd0 : (e < 7) ? 2'd1 : 2'd2;
      tests_run++;
      if (state_o !== exp_state) begin
        tests_failed++;
        $display("FAIL select_state edge=%0d state=%0d required %0d", e, state_o, exp_state);
      end
      if (e == 6) begin
        tests_run++;
        if (proj_rst_n !== 4'b0000 || io_oeb !== OEB_OFF) begin
          tests_failed++;
          $display("FAIL select_guard_pads rst_n=%b oeb=%h required 0000 / all 1", proj_rst_n, io_oeb);
        end
      end
    end
    tests_run++;
    if (proj_rst_n !== 4'b0010 || sel_o !== 2'd1 || switch_cnt_o !== 8'd1) begin
      tests_failed++;
      $display("FAIL select_run rst_n=%b sel=%0d swc=%0d required 0010 1 1", proj_rst_n, sel_o, switch_cnt_o);
    end
    tests_run++;
    if (io_out !== io_pat(1) || io_oeb !== oeb_pat(1) || la_data_out !== la_pat(1)) begin
      tests_failed++;
      $display("FAIL select_route io_out=%h oeb=%h la=%h required %h %h %h",
               io_out, io_oeb, la_data_out, io_pat(1), oeb_pat(1), la_pat(1));
    end
  endtask

  task automatic test_handover();
    logic [1:0] exp_state;
    logic [3:0] exp_rst;
    active_i = 32'h0000_0800;  // project 3
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_state = (e < 3) ? 2'd2 : (e < 7) ? 2'd1 : 2'd2;
      exp_rst   = (e < 3) ? 4'b0010 : (e < 7) ? 4'b0000 : 4'b1000;
      tests_run++;
      if (state_o !== exp_state || proj_rst_n !== exp_rst) begin
        tests_failed++;
        $display("FAIL handover_seq edge=%0d state=%0d rst_n=%b required %0d %b",
                 e, state_o, proj_rst_n, exp_state, exp_rst);
      end
      if (e >= 3 && e < 7) begin
        tests_run++;
        if (io_oeb !== OEB_OFF || io_out !== '0 || sel_o !== 2'd3) begin
          tests_failed++;
          $display("FAIL handover_guard edge=%0d oeb=%h io_out=%h sel=%0d required all 1 / 0 / 3",
                   e, io_oeb, io_out, sel_o);
        end
      end
    end
    tests_run++;
    if (switch_cnt_o !== 8'd2 || io_out !== io_pat(3) || la_data_out !== la_pat(3)) begin
      tests_failed++;
      $display("FAIL handover_run swc=%0d io_out=%h la=%h required 2 %h %h",
               switch_cnt_o, io_out, la_data_out, io_pat(3), la_pat(3));
    end
  endtask

  task automatic test_fault();
    active_i = 32'h0000_0500;  // bits 8 and 10 together
    repeat (2) tick();
    tests_run++;
    if (state_o !== 2'd2) begin
      tests_failed++;
      $display("FAIL fault_latency state=%0d required 2", state_o);
    end
    tick();
    tests_run++;
    if (state_o !== 2'd3 || fault_o !== 1'b1 || proj_rst_n !== 4'b0000 || io_oeb !== OEB_OFF) begin
      tests_failed++;
      $display("FAIL fault_enter state=%0d fault=%b rst_n=%b oeb=%h required 3 1 0000 all 1",
               state_o, fault_o, proj_rst_n, io_oeb);
    end
    active_i = 32'h0000_0100;  // project 0 only
    repeat (3) tick();
    tests_run++;
    if (state_o !== 2'd1 || sel_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL fault_exit state=%0d sel=%0d required 1 0", state_o, sel_o);
    end
    repeat (4) tick();
    tests_run++;
    if (state_o !== 2'd2 || proj_rst_n !== 4'b0001 || fault_o !== 1'b1 || switch_cnt_o !== 8'd3) begin
      tests_failed++;
      $display("FAIL fault_recover state=%0d rst_n=%b fault=%b swc=%0d required 2 0001 1 3",
               state_o, proj_rst_n, fault_o, switch_cnt_o);
    end
    tests_run++;
    if (la_data_out !== la_pat(0) || io_out !== io_pat(0)) begin
      tests_failed++;
      $display("FAIL fault_route la=%h io_out=%h required %h %h", la_data_out, io_out, la_pat(0), io_pat(0));
    end
  endtask

  task automatic test_toggle();
    int e;
    e = 0;
    for (int i = 0; i < 10; i++) begin
      active_i = (i % 2 == 1) ? 32'h0000_0400 : 32'h0000_0200;
      repeat (2) begin
        tick();
        e++;
        if (e >= 3) begin
          tests_run++;
          if (state_o !== 2'd1 || io_oeb !== OEB_OFF || proj_rst_n !== 4'b0000) begin
            tests_failed++;
            $display("FAIL toggle_guard edge=%0d state=%0d oeb=%h rst_n=%b required 1 all 1 0000",
                     e, state_o, io_oeb, proj_rst_n);
          end
        end
      end
    end
    tests_run++;
    if (switch_cnt_o !== 8'd3) begin
      tests_failed++;
      $display("FAIL toggle_count swc=%0d required 3", switch_cnt_o);
    end
    // Same in-window request (project 2). The bits outside the window must be ignored.
    active_i = 32'h8000_04FF;
    repeat (5) tick();
    tests_run++;
    if (state_o !== 2'd2 || sel_o !== 2'd2 || switch_cnt_o !== 8'd4 || io_out !== io_pat(2)) begin
      tests_failed++;
      $display("FAIL toggle_settle state=%0d sel=%0d swc=%0d io_out=%h required 2 2 4 %h",
               state_o, sel_o, switch_cnt_o, io_out, io_pat(2));
    end
  endtask

  task automatic test_release();
    active_i = 32'h0000_0000;
    repeat (2) tick();
    tests_run++;
    if (state_o !== 2'd2) begin
      tests_failed++;
      $display("FAIL release_latency state=%0d required 2", state_o);
    end
    tick();
    tests_run++;
    if (state_o !== 2'd0 || proj_rst_n !== 4'b0000 || io_oeb !== OEB_OFF) begin
      tests_failed++;
      $display("FAIL release_off state=%0d rst_n=%b oeb=%h required 0 0000 all 1", state_o, proj_rst_n, io_oeb);
    end
  endtask

  task automatic test_reset_mid_run();
    active_i = 32'h0000_0800;
    repeat (7) tick();
    tests_run++;
    if (state_o !== 2'd2 || proj_rst_n !== 4'b1000) begin
      tests_failed++;
      $display("FAIL midrun_setup state=%0d rst_n=%b required 2 1000", state_o, proj_rst_n);
    end
    #3;
    wb_rst_n = 1'b0;
    #1;
    tests_run++;
    if (io_oeb !== OEB_OFF || proj_rst_n !== 4'b0000 || io_out !== '0 || state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL midrun_async oeb=%h rst_n=%b io_out=%h state=%0d required all 1 0000 0 0",
               io_oeb, proj_rst_n, io_out, state_o);
    end
    tests_run++;
    if (switch_cnt_o !== 8'd0 || fault_o !== 1'b0 || sel_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL midrun_regs swc=%0d fault=%b sel=%0d required 0 0 0", switch_cnt_o, fault_o, sel_o);
    end
    active_i = '0;
    repeat (2) tick();
    wb_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 300; n++) begin
      active_i = (n % 2 == 1) ? 32'h0000_0100 : 32'h0000_0200;
      repeat (8) tick();
      if (n == 254 || n == 255) begin
        tests_run++;
        if (switch_cnt_o !== 8'(n)) begin
          tests_failed++;
          $display("FAIL sat_count n=%0d swc=%0d required %0d", n, switch_cnt_o, n);
        end
      end
    end
    tests_run++;
    if (switch_cnt_o !== 8'd255 || state_o !== 2'd2 || sel_o !== 2'd1) begin
      tests_failed++;
      $display("FAIL sat_final swc=%0d state=%0d sel=%0d required 255 2 1", switch_cnt_o, state_o, sel_o);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    wb_rst_n    = 1'b0;
    active_i    = '0;
    proj_io_out = '0;
    proj_io_oeb = '0;
    proj_la_out = '0;
    drive_projects();

    test_reset();
    test_select();
    test_handover();
    test_fault();
    test_toggle();
    test_release();
    test_reset_mid_run();
    test_saturation();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
